// File: rtl/uc_port_pkg.sv
// rtl/uc_port_pkg.sv - shared states, select encoding and sizes for the uc RAM port master
package uc_port_pkg;

    localparam int RAM_AW  = 15;
    localparam int MAX_LEN = 32768;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_LO,
        S_LOAD_HI,
        S_FETCH,
        S_REQ,
        S_REL,
        S_INC,
        S_DELIVER,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LO,
        SEL_HI
    } sel_t;

    // High address byte as the CPLD expects it: bit 7 is always zero.
    function automatic logic [7:0] addr_hi_byte(input logic [RAM_AW-1:0] a);
        return {1'b0, a[RAM_AW-1:8]};
    endfunction

endpackage

// File: rtl/uc_ram_port_master_if.sv
// rtl/uc_ram_port_master_if.sv - CPLD uc RAM port signal bundle
interface uc_ram_port_master_if;

    logic [7:0] uc_data_out;
    logic       uc_data_oe;
    logic [7:0] uc_data_in;
    logic       uc_read;
    logic       uc_write;
    logic       set_addr_lo;
    logic       set_addr_hi;
    logic       strobe_addr;
    logic       uc_ack;

    modport master (
        output uc_data_out, uc_data_oe, uc_read, uc_write,
               set_addr_lo, set_addr_hi, strobe_addr,
        input  uc_data_in, uc_ack
    );

    modport slave (
        input  uc_data_out, uc_data_oe, uc_read, uc_write,
               set_addr_lo, set_addr_hi, strobe_addr,
        output uc_data_in, uc_ack
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous CPLD inputs
// Deliberately unreset so a level held through reset is still seen right after it.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/uc_ram_port_master.sv
// rtl/uc_ram_port_master.sv - burst master driving the cartridge CPLD uc RAM port
module uc_ram_port_master
    import uc_port_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 2,
    parameter int HOLD_CYC    = 1,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [RAM_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              error,
    uc_ram_port_master_if.master uc
);

    localparam int STRB_LEN = SETUP_CYC + STROBE_CYC + HOLD_CYC;
    localparam int TMR_MAX  = (ACK_TIMEOUT > STRB_LEN) ? ACK_TIMEOUT : STRB_LEN;
    localparam int TW       = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0] STRB_ON  = TW'(SETUP_CYC);
    localparam logic [TW-1:0] STRB_OFF = TW'(SETUP_CYC + STROBE_CYC);
    localparam logic [TW-1:0] STRB_END = TW'(STRB_LEN - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(ACK_TIMEOUT - 1);

    state_t            state, state_d;
    logic [TW-1:0]     tmr;
    logic [RAM_AW-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              dir;
    logic [7:0]        wbyte;
    logic [7:0]        rbyte;

    logic              ack_s;
    sel_t              sel;
    logic              strobe;
    logic [7:0]        data;
    logic              oe;
    logic              rd_en;
    logic              wr_en;
    logic              cmd_fire;
    logic              strb_last;
    logic              in_strobe;
    logic              timeout;

    sync_2ff #(.WIDTH(1)) u_ack_sync (
        .clk (clk),
        .d   (uc.uc_ack),
        .q   (ack_s)
    );

    // A new command waits until the CPLD has released ack from any aborted cycle.
    assign cmd_ready = (state == S_IDLE) && !ack_s && !rst;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // One timer serves both the strobe phase and the ack timeout; it restarts on every state change.
    assign strb_last = (tmr == STRB_END);
    assign in_strobe = (tmr >= STRB_ON) && (tmr < STRB_OFF);
    assign timeout   = (tmr == TMO_END) &&
                       (((state == S_REQ) && !ack_s) || ((state == S_REL) && ack_s));

    always_comb begin
        state_d  = state;
        sel      = SEL_NONE;
        strobe   = 1'b0;
        data     = 8'h00;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wr_ready = 1'b0;
        rd_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_fire) state_d = (cmd_len == '0) ? S_DONE : S_LOAD_LO;
            end
            S_LOAD_LO: begin
                sel    = SEL_LO;
                data   = addr[7:0];
                strobe = in_strobe;
                if (strb_last) state_d = S_LOAD_HI;
            end
            S_LOAD_HI: begin
                sel    = SEL_HI;
                data   = addr_hi_byte(addr);
                strobe = in_strobe;
                if (strb_last) state_d = dir ? S_REQ : S_FETCH;
            end
            S_FETCH: begin
                wr_ready = 1'b1;
                if (wr_valid) state_d = S_REQ;
            end
            S_REQ: begin
                rd_en = dir;
                wr_en = !dir;
                if (!dir) data = wbyte;
                if (timeout)    state_d = S_IDLE;
                else if (ack_s) state_d = S_REL;
            end
            S_REL: begin
                if (timeout)     state_d = S_IDLE;
                else if (!ack_s) state_d = S_INC;
            end
            S_INC: begin
                strobe = in_strobe;
                if (strb_last) begin
                    if (dir)                      state_d = S_DELIVER;
                    else if (len == LEN_W'(1))    state_d = S_DONE;
                    else                          state_d = S_FETCH;
                end
            end
            S_DELIVER: begin
                rd_valid = 1'b1;
                if (rd_ready) state_d = (len == '0) ? S_DONE : S_REQ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        oe = (sel != SEL_NONE) || wr_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            tmr   <= '0;
            addr  <= '0;
            len   <= '0;
            dir   <= 1'b0;
            wbyte <= 8'h00;
            rbyte <= 8'h00;
            error <= 1'b0;
        end else begin
            state <= state_d;
            tmr   <= (state_d != state) ? '0 : tmr + 1'b1;
            if (cmd_fire) begin
                addr  <= cmd_addr;
                len   <= cmd_len;
                dir   <= cmd_read;
                error <= 1'b0;
            end
            if (timeout) error <= 1'b1;
            if ((state == S_FETCH) && wr_valid) wbyte <= wr_data;
            if ((state == S_REQ) && ack_s && dir) rbyte <= uc.uc_data_in;
            if ((state == S_INC) && strb_last) begin
                addr <= addr + 1'b1;
                len  <= len - 1'b1;
            end
        end
    end

    assign busy           = (state != S_IDLE);
    assign rd_data        = rbyte;
    assign uc.uc_data_out = data;
    assign uc.uc_data_oe  = oe;
    assign uc.uc_read     = rd_en;
    assign uc.uc_write    = wr_en;
    assign uc.set_addr_lo = (sel == SEL_LO);
    assign uc.set_addr_hi = (sel == SEL_HI);
    assign uc.strobe_addr = strobe;

endmodule

// File: doc/uc_ram_port_master.md
Name: uc_ram_port_master

Overview:
- Microcontroller-side master for the cartridge CPLD's uc RAM port; sits directly upstream of the CPLD's uc_data/uc_read/uc_write/set_addr_*/strobe_addr/uc_ack interface.
- Converts burst commands (start address, length, direction) plus byte streams into the CPLD's address-load, strobe and four-phase ack handshakes.
- Used by SD-card loader firmware logic to fill or dump the 32 KiB cartridge RAM.

Parameters:
- SETUP_CYC, 2, clk cycles uc_data/selects are stable before strobe_addr rises
- STROBE_CYC, 2, clk cycles strobe_addr is held high
- HOLD_CYC, 1, clk cycles uc_data/selects are held after strobe_addr falls
- ACK_TIMEOUT, 4096, clk cycles allowed for each uc_ack edge before abort

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_read  in  1  1 = RAM-to-host read burst, 0 = host-to-RAM write burst
- cmd_addr  in  15  start RAM address
- cmd_len  in  16  byte count, 0..32768; 0 = no transfer
- wr_data  in  8  write byte
- wr_valid  in  1  write byte offered
- wr_ready  out  1  write byte consumed
- rd_data  out  8  read byte
- rd_valid  out  1  read byte available
- rd_ready  in  1  read byte consumed
- busy  out  1  command in progress
- error  out  1  sticky ack timeout flag
- uc_data_out  out  8  data toward CPLD
- uc_data_oe  out  1  drive enable for uc_data
- uc_data_in  in  8  data from CPLD
- uc_read, uc_write, set_addr_lo, set_addr_hi, strobe_addr  out  1 each  CPLD control lines
- uc_ack  in  1  CPLD ack, asynchronous to clk

Behaviour:
- Reset value of every output is 0; the FSM enters IDLE. Reset mid-burst drops all control lines in the same cycle. No attempt is made to complete the burst; the next command reloads the address.
- uc_ack passes through a 2-flop synchronizer (ack_s), giving 2 cycles of latency.
- cmd_ready = IDLE & ~ack_s. On acceptance: error clears, busy rises next cycle, and addr, len and dir are latched. A len of 0 returns to IDLE after one cycle and issues no strobes.
- Strobe sequence STRB(sel):
  - Select line (set_addr_lo, set_addr_hi or neither) and uc_data are held for SETUP_CYC cycles.
  - strobe_addr is then high for STROBE_CYC cycles.
  - It is then low for HOLD_CYC cycles before the select line drops.
  - uc_data_oe is 1 for the whole sequence when sel is lo or hi.
- FSM states:
  - IDLE
  - LOAD_LO: STRB(lo) with addr[7:0]
  - LOAD_HI: STRB(hi) with {1'b0, addr[14:8]}
  - then, per byte: FETCH, REQ, REL, INC, DELIVER
  - DONE, then back to IDLE
- FETCH (write only): wr_ready=1 until the handshake; the byte is registered into uc_data_out and oe=1.
- REQ: assert uc_write (write) or uc_read (read) and wait for ack_s=1.
  - On a read, capture uc_data_in on the first cycle ack_s=1.
  - oe stays 1 on writes and 0 on reads.
- REL: drop uc_write/uc_read and wait for ack_s=0. oe drops on entry to REL.
- INC: STRB(none), pulsing strobe_addr with no selects so the CPLD post-increments its address. This happens after every byte, including the last. The internal addr mirror increments modulo 2^15 (0x7FFF wraps to 0x0000).
- DELIVER (read only): rd_valid=1 holding the captured byte until rd_ready. Backpressure stalls only in this state; the CPLD sees nothing during the stall.
- len decrements after INC. When len reaches 0, go to DONE; busy drops on the IDLE entry.
- uc_read and uc_write are never high simultaneously. Neither is high during any strobe sequence.
- Timeout: a counter resets on entry to REQ or REL. If it reaches ACK_TIMEOUT:
  - set error
  - drop all control lines
  - go to IDLE
  - leave the remaining len untransferred

Decomposition:
- Shared package uc_port_pkg holds:
  - state enum
  - select encoding (SEL_NONE/SEL_LO/SEL_HI)
  - RAM_AW=15 and the max length constant 32768
- One sub-module, sync_2ff, for uc_ack (reusable for other async CPLD inputs).
- Strobe timing is a phase counter inside the main FSM, not a separate module.

Test Plan:
- Write cmd addr=0x1234, len=3, bytes A5/5A/FF, CPLD model acking after 20 cycles:
  - set_addr_lo strobe with uc_data=0x34, then set_addr_hi with 0x12
  - model RAM[0x1234..0x1236] = A5,5A,FF
  - exactly 3 bare strobes; busy low afterward
- Read cmd addr=0x7FFE, len=3 with model RAM preset 11/22/33 at 7FFE/7FFF/0000:
  - rd_data sequence 11,22,33
  - model address wraps to 0x0000 then 0x0001
- Read with rd_ready held low 50 cycles on byte 2: no uc_read/strobe activity during the stall; data intact.
- Model never acks the write: error=1 after ACK_TIMEOUT+2 cycles; uc_write=0; back in IDLE. The next command clears error.
- len=0 command: no strobes, no uc_write/uc_read; busy high exactly one cycle.
- rst asserted mid-REQ with uc_ack stuck high:
  - all outputs 0 in the following cycle
  - cmd_ready stays 0 until ack_s falls
